// File: rtl/pp_pipeline_accel_pkg.sv
// Shared constants and types for the pipelined accelerator dataflow controller.
package pp_pipeline_accel_pkg;

  localparam int NUM_PROC_DEF     = 3;
  localparam int MAX_INFLIGHT_DEF = 2;

  localparam int PROC_ENTRY = 0;
  localparam int PROC_PRE   = 1;
  localparam int PROC_WB    = 2;

  // Occupancy view of the in-flight counter; a pending done is tracked separately.
  typedef enum logic [1:0] {
    OCC_IDLE = 2'd0,
    OCC_BUSY = 2'd1,
    OCC_FULL = 2'd2
  } occ_state_e;

  function automatic occ_state_e occ_state(input logic empty, input logic full);
    if (full)  return OCC_FULL;
    if (empty) return OCC_IDLE;
    return OCC_BUSY;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_df_ctrl_if.sv
// ap_ctrl_chain handshake to the host plus the per-process handshake bundle.
interface pp_pipeline_accel_df_ctrl_if
  import pp_pipeline_accel_pkg::*;
#(
  parameter int NUM_PROC     = NUM_PROC_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic                ap_start;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_continue;
  logic                ap_idle;
  logic [NUM_PROC-1:0] proc_start;
  logic [NUM_PROC-1:0] proc_ready;
  logic [NUM_PROC-1:0] proc_done;
  logic [NUM_PROC-1:0] proc_continue;
  logic [NUM_PROC-1:0] proc_idle;
  logic [CNT_W-1:0]    inflight_cnt;

  modport slave (
    input  ap_start, ap_continue, proc_ready, proc_done, proc_idle,
    output ap_ready, ap_done, ap_idle, proc_start, proc_continue, inflight_cnt
  );

  modport master (
    output ap_start, ap_continue, proc_ready, proc_done, proc_idle,
    input  ap_ready, ap_done, ap_idle, proc_start, proc_continue, inflight_cnt
  );
endinterface

// File: rtl/pp_pipeline_accel_sync_latch.sv
// Per-process sticky flag: set on an event, cleared when the iteration moves on.
module pp_pipeline_accel_sync_latch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);
  logic q_q, q_d;

  // Clear wins so a flag never leaks into the next iteration.
  always_comb begin
    q_d = q_q;
    if (clr_i)      q_d = 1'b0;
    else if (set_i) q_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/pp_pipeline_accel_df_ctrl.sv
// Dataflow controller: fans the top-level ap_ctrl_chain start out to each
// process, joins their ready/done back, and bounds overlapped iterations.
module pp_pipeline_accel_df_ctrl
  import pp_pipeline_accel_pkg::*;
#(
  parameter int NUM_PROC     = NUM_PROC_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input logic                        ap_clk,
  input logic                        ap_rst,
  pp_pipeline_accel_df_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [NUM_PROC-1:0] rdy_lat, done_lat, rdy_set, done_set, proc_cont;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_pend_q, done_pend_d;
  logic                can_accept, top_ready, retire;
  occ_state_e          occ;

  always_comb begin
    occ         = occ_state(cnt_q == '0, cnt_q == MAX_CNT);
    can_accept  = bus.ap_start & (occ != OCC_FULL);
    top_ready   = can_accept & (&(rdy_lat | bus.proc_ready));
    retire      = done_pend_q & bus.ap_continue;
    proc_cont   = ~done_lat & ~{NUM_PROC{done_pend_q}};
    rdy_set     = {NUM_PROC{can_accept}} & bus.proc_ready;
    done_set    = bus.proc_done & proc_cont;

    cnt_d = cnt_q;
    case ({top_ready, retire})
      2'b10:   cnt_d = cnt_q + ONE_CNT;
      2'b01:   cnt_d = cnt_q - ONE_CNT;
      default: cnt_d = cnt_q;
    endcase

    // Retire takes priority: done_lat clears on the same edge, so no re-arm.
    done_pend_d = done_pend_q;
    if (retire)         done_pend_d = 1'b0;
    else if (&done_lat) done_pend_d = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q       <= '0;
      done_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      done_pend_q <= done_pend_d;
    end
  end

  for (genvar i = 0; i < NUM_PROC; i++) begin : g_proc
    pp_pipeline_accel_sync_latch u_rdy_lat (
      .clk_i (ap_clk),
      .rst_i (ap_rst),
      .set_i (rdy_set[i]),
      .clr_i (top_ready),
      .q_o   (rdy_lat[i])
    );
    pp_pipeline_accel_sync_latch u_done_lat (
      .clk_i (ap_clk),
      .rst_i (ap_rst),
      .set_i (done_set[i]),
      .clr_i (retire),
      .q_o   (done_lat[i])
    );
  end

  assign bus.proc_start    = {NUM_PROC{can_accept}} & ~rdy_lat;
  assign bus.ap_ready      = top_ready;
  assign bus.ap_done       = done_pend_q;
  assign bus.proc_continue = proc_cont;
  assign bus.ap_idle       = ~bus.ap_start & (occ == OCC_IDLE) & (&bus.proc_idle);
  assign bus.inflight_cnt  = cnt_q;

  a_no_overflow: assert property (@(posedge ap_clk) disable iff (ap_rst)
    !(top_ready && !retire && cnt_q == MAX_CNT));
  a_no_underflow: assert property (@(posedge ap_clk) disable iff (ap_rst)
    !(retire && !top_ready && cnt_q == '0));
endmodule
